alu_md_seq: RTL
===============

// Module: alu_md_seq
// PURPOSE
//  Sequential execute unit: RV32I/RV64I R-type and I-type integer ops plus the M-extension
//  (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), width-parametrised to XLEN.
//  Sits between decode/operand-read and writeback; valid/ready in and out; one op in flight.
//  Simple ops take one cycle, MUL a registered stage, DIV/REM an iterative radix-2 divider.
//  Shift amounts are masked to log2(XLEN) bits; SLLI uses shamt; illegal encodings are flagged.
// PARAMETERS
//  XLEN        32   operand/result width (32 or 64)
//  MUL_STAGES  1    extra register stages after the combinational multiplier (1..3)
//  ILLEGAL_VAL 'hDEADC0DE  result driven (zero-extended to XLEN) when illegal_o=1
// PORTS
//  clk_i        in   1     clock, rising edge
//  rst_ni       in   1     asynchronous reset, active low
//  flush_i      in   1     abort any op in flight; highest priority after reset
//  in_valid_i   in   1     instruction/operands valid
//  in_ready_o   out  1     unit can accept an op (state IDLE)
//  instruction_i in  32    raw instruction: opcode[6:0], funct3[14:12], funct7[31:25], imm[31:20]
//  rs1_data_i   in   XLEN  operand A
//  rs2_data_i   in   XLEN  operand B (ignored for I-type)
//  out_valid_o  out  1     result valid (state DONE)
//  out_ready_i  in   1     consumer accepts result
//  result_o     out  XLEN  result, held stable while out_valid_o=1
//  illegal_o    out  1     opcode/funct3/funct7 combination not supported; qualified by out_valid_o
// BEHAVIOUR
//  Reset: state=IDLE, in_ready_o=1, out_valid_o=0, result_o=0, illegal_o=0, divider regs=0.
//  Accept when in_valid_i&in_ready_o; instruction and operands captured, inputs then don't-care.
//  FSM: IDLE -(simple or illegal)-> DONE; IDLE -(MUL*)-> MUL; IDLE -(DIV*/REM*)-> DIV;
//   MUL: count MUL_STAGES cycles -> DONE; DIV: XLEN iterations -> FIX (sign/special fix) -> DONE;
//   DONE -(out_ready_i)-> IDLE. No accept in DONE (no bypass); in_ready_o=0 outside IDLE.
//  Latency accept->out_valid_o: simple 1; MUL 1+MUL_STAGES; DIV/REM XLEN+2 cycles.
//  Opcodes: 0110011 R-type (funct7 0000000/0100000 base, 0000001 M-ext); 0010011 I-type.
//   Any other opcode, or funct7 not in {0000000, 0100000 for SUB/SRA only, 0000001 R-type only},
//   or I-type shift with imm[11:SHW] not in {0, 0100000 pattern for SRAI} -> illegal, 1 cycle.
//  Width rules: SHW=$clog2(XLEN); shift amount = rs2[SHW-1:0] or instruction_i[20+:SHW].
//   imm sign-extended to XLEN for all I-type incl. SLTIU (unsigned compare of sign-ext value).
//   SRA/SRAI arithmetic ($signed); SLT/SLTU result zero-extended 0/1; add/sub wrap modulo 2^XLEN.
//   MUL low XLEN bits; MULH s*s, MULHSU s*u, MULHU u*u upper XLEN bits of 2*XLEN product.
//  Divider: operate on magnitudes, sign-fix in FIX. Divide by zero: DIV/DIVU q=all-ones,
//   REM/REMU r=rs1. Signed overflow (rs1=-2^(XLEN-1), rs2=-1): q=rs1, r=0. Special cases still
//   take full XLEN+2 latency (fixed latency).
//  Back-pressure: DONE holds result_o/illegal_o/out_valid_o until out_ready_i; unbounded stall.
//  flush_i: any state -> IDLE next cycle, out_valid_o=0, result dropped; flush in IDLE with
//   in_valid_i=1 does not accept. Async reset mid-DIV returns to reset values immediately.
// TESTING
//  XLEN=32: ADD 0x7FFFFFFF+1 -> 0x80000000, illegal=0, out_valid 1 cycle after accept.
//  SRAI shamt=4 on 0x80000000 -> 0xF8000000; SLL rs2=0x21 -> shift by 1 (masked).
//  DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000, REM 0; all at XLEN+2.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE.
//  Hold out_ready_i=0 10 cycles in DONE -> result stable, in_ready_o=0; release -> IDLE next cycle.
//  flush_i at DIV cycle 5 -> no out_valid_o, next ADD correct; opcode 0x7F -> illegal_o=1, result 0xDEADC0DE.

Source files
------------

// File: rtl/alu_md_seq.sv
// Sequential RV32I/RV64I + M-extension execute unit. Accepts one op at a time and
// returns its result after a fixed, op-class dependent latency.
module alu_md_seq #(
  parameter int          XLEN        = 32,
  parameter int          MUL_STAGES  = 1,
  parameter logic [31:0] ILLEGAL_VAL = 32'hDEADC0DE
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int HIW = 12 - SHW;
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [HIW-1:0]  SRAI_PAT = HIW'(1) << (10 - SHW);
  localparam logic [6:0]      OPC_R    = 7'b0110011;
  localparam logic [6:0]      OPC_I    = 7'b0010011;
  localparam logic [XLEN-1:0] ILL_RES  = XLEN'(ILLEGAL_VAL);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  typedef enum logic [1:0] {K_SIMPLE, K_MUL, K_DIV, K_ILLEGAL} kind_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] div_q, div_r, div_d;
  logic            neg_q, neg_r, div_zero;

  // Decode fields of the incoming instruction
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [HIW-1:0]  imm_hi;
  logic            is_r;
  logic [XLEN-1:0] imm_sext, opb;
  logic [SHW-1:0]  shamt;
  kind_t           kind;
  logic [XLEN-1:0] simple_res;

  assign opcode   = instruction_i[6:0];
  assign funct3   = instruction_i[14:12];
  assign funct7   = instruction_i[31:25];
  assign imm_hi   = instruction_i[31:20+SHW];
  assign is_r     = (opcode == OPC_R);
  assign imm_sext = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};
  assign opb      = is_r ? rs2_data_i : imm_sext;
  assign shamt    = is_r ? rs2_data_i[SHW-1:0] : instruction_i[20+:SHW];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    kind = K_ILLEGAL;
    if (is_r) begin
      case (funct7)
        7'b0000001: kind = funct3[2] ? K_DIV : K_MUL;
        7'b0000000: kind = K_SIMPLE;
        7'b0100000: if (funct3 == 3'b000 || funct3 == 3'b101) kind = K_SIMPLE;
        default:    kind = K_ILLEGAL;
      endcase
    end else if (opcode == OPC_I) begin
      case (funct3)
        3'b001:  if (imm_hi == '0) kind = K_SIMPLE;
        3'b101:  if (imm_hi == '0 || imm_hi == SRAI_PAT) kind = K_SIMPLE;
        default: kind = K_SIMPLE;
      endcase
    end
  end

  always_comb begin
    simple_res = '0;
    case (funct3)
      3'b000: begin
        if (is_r && instruction_i[30]) simple_res = rs1_data_i - opb;
        else                           simple_res = rs1_data_i + opb;
      end
      3'b001: simple_res = rs1_data_i << shamt;
      3'b010: simple_res = {{(XLEN-1){1'b0}}, $signed(rs1_data_i) < $signed(opb)};
      3'b011: simple_res = {{(XLEN-1){1'b0}}, rs1_data_i < opb};
      3'b100: simple_res = rs1_data_i ^ opb;
      3'b101: begin
        // Kept as if/else: a ternary would make the arithmetic arm unsigned
        if (instruction_i[30]) simple_res = $signed(rs1_data_i) >>> shamt;
        else                   simple_res = rs1_data_i >> shamt;
      end
      3'b110: simple_res = rs1_data_i | opb;
      default: simple_res = rs1_data_i & opb;
    endcase
  end

  // Divider runs on magnitudes; signs are reapplied in FIX
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_res;

  assign a_neg     = ~funct3[0] & rs1_data_i[XLEN-1];
  assign b_neg     = ~funct3[0] & rs2_data_i[XLEN-1];
  assign a_mag     = a_neg ? -rs1_data_i : rs1_data_i;
  assign b_mag     = b_neg ? -rs2_data_i : rs2_data_i;
  assign div_shift = {div_r, div_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, div_d};
  assign div_ge    = div_shift >= {1'b0, div_d};

  always_comb begin
    div_res = '0;
    if (!f3_q[1]) div_res = div_zero ? '1 : (neg_q ? -div_q : div_q);
    else          div_res = div_zero ? op_a : (neg_r ? -div_r : div_r);
  end

  // Full 2*XLEN product from sign- or zero-extended operands
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_a    = {{XLEN{(f3_q[1:0] != 2'b11) & op_a[XLEN-1]}}, op_a};
    mul_b    = {{XLEN{~f3_q[1] & op_b[XLEN-1]}}, op_b};
    mul_prod = mul_a * mul_b;
    mul_res  = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  logic unused_bits;
  assign unused_bits = ^{instruction_i[19:15], instruction_i[11:7], div_diff[XLEN]};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      illegal_o   <= 1'b0;
      cnt         <= '0;
      f3_q        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      div_q       <= '0;
      div_r       <= '0;
      div_d       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
    end else if (flush_i) begin
      state       <= S_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            f3_q       <= funct3;
            op_a       <= rs1_data_i;
            op_b       <= rs2_data_i;
            cnt        <= '0;
            in_ready_o <= 1'b0;
            illegal_o  <= 1'b0;
            case (kind)
              K_SIMPLE: begin
                result_o    <= simple_res;
                out_valid_o <= 1'b1;
                state       <= S_DONE;
              end
              K_MUL: state <= S_MUL;
              K_DIV: begin
                div_q    <= a_mag;
                div_r    <= '0;
                div_d    <= b_mag;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (rs2_data_i == '0);
                state    <= S_DIV;
              end
              default: begin
                result_o    <= ILL_RES;
                illegal_o   <= 1'b1;
                out_valid_o <= 1'b1;
                state       <= S_DONE;
              end
            endcase
          end
        end
        S_MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MUL_STAGES - 1)) begin
            result_o    <= mul_res;
            out_valid_o <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DIV: begin
          div_r <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          div_q <= {div_q[XLEN-2:0], div_ge};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= S_FIX;
        end
        S_FIX: begin
          result_o    <= div_res;
          out_valid_o <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
